mu0_run_ctrl: RTL and testbench
===============================

// Module: mu0_run_ctrl
// PURPOSE
//  Run/clock sequencer for the mu0 core. It turns the UART start toggle, the core's done
//  flag and the 4-bit clock mode into a gated CPU clock level plus a one-cycle edge strobe.
//  It also provides a run-state FSM and a cycle counter for the debug link. Sits between
//  the uart block and mu0 in the top level and replaces the ad-hoc enable/slowClk logic.
// PARAMETERS
//  SLOW_DIV  6318000  fast-clk cycles per half-period in SLOW mode, minus 1
//  CNT_W     32       width of the SLOW-mode divider counter
//  PC_W      16       width of pc / bpAddr
// PORTS
//  clk         in   1      system clock; the only clock
//  reset       in   1      asynchronous, active-high reset
//  clkMode     in   4      0 OFF, 1 FAST, 2 SLOW, 3 MANUAL_OFF, 4 MANUAL_ON, 5..15 = OFF
//  start       in   1      level toggled by uart; any change = run request
//  done        in   1      core finished (level, sampled on clk)
//  cpuClk      out  1      registered CPU clock level, already gated by enable
//  cpuEdge     out  1      1-cycle pulse in the clk cycle where cpuClk goes 0->1
//  enable      out  1      core enabled (state == RUN)
//  haltReason  out  2      0 none/idle, 1 done, 2 breakpoint, 3 reserved
//  cycleCount  out  16     cpuEdge count since last run start, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (async): every output 0; state IDLE; divider 0; startSeen 0; primed 0.
//  - First clk after reset: startSeen <= start, primed <= 1. No run request in that cycle.
//  - Run request: primed && start != startSeen. startSeen <= start on every request.
//  FSM, states IDLE, RUN, HALT (BREAK with BREAKPOINT_EN); all transitions take 1 clk:
//  - IDLE/HALT/BREAK + request -> RUN. haltReason <= 0, cycleCount <= 0.
//  - RUN + done -> HALT, haltReason <= 1. A request in the same cycle wins: stay RUN, clear counters.
//  - enable = (state == RUN), registered; it falls in the clk after done is sampled.
//  Clock generator level g (always running, independent of state):
//  - OFF / 5..15: g = 0.  MANUAL_OFF: g = 0.  MANUAL_ON: g = 1.
//  - FAST: g toggles every clk, giving clk/2.
//  - SLOW: divider counts 0..SLOW_DIV; at SLOW_DIV g toggles and divider <= 0.
//    Half-period = SLOW_DIV+1 clks.
//  - A clkMode change (registered compare) clears the divider in the same cycle.
//    g takes the new mode's value next clk.
//  - cpuClk <= g & (next state == RUN). Leaving RUN forces cpuClk low in the same clk as enable.
//  - cpuEdge = cpuClk rising (registered compare of cpuClk with its previous value).
//    It never fires outside RUN.
//  - cycleCount increments on cpuEdge and holds at 16'hFFFF; it is held in IDLE/HALT/BREAK.
//  - Reset mid-run: immediate return to the reset values above; no clock glitch beyond the
//    async clear of cpuClk.
// CONFIGURATION
//  MU0_BREAKPOINT_EN defined:
//  - Adds inputs pc[PC_W-1:0], bpAddr[PC_W-1:0] and bpArm (1 bit).
//  - In RUN, on a clk with cpuEdge && bpArm && pc == bpAddr: go to BREAK, haltReason <= 2,
//    enable and cpuClk low next clk.
//  - done in the same cycle takes precedence: HALT, reason 1. A request resumes from BREAK.
//  Not defined: those ports do not exist, BREAK is unreachable, haltReason is never 2.
// TESTING
//  1. reset with start=1, release, hold 4 clks -> enable stays 0, state IDLE (no spurious run).
//  2. FAST, toggle start -> enable=1 next clk; cpuEdge every 2nd clk; cycleCount=5 after 10 clks.
//  3. SLOW with SLOW_DIV=3, run -> cpuClk period 8 clks; switch to FAST mid-count ->
//     divider cleared, clk/2 from next clk.
//  4. RUN, done=1 for 1 clk -> next clk enable=0, cpuClk=0, haltReason=1, cycleCount frozen.
//     done and start toggle together -> stays RUN, cycleCount=0.
//  5. MANUAL_OFF->MANUAL_ON->MANUAL_OFF x3 in RUN -> exactly 3 cpuEdge pulses, cycleCount=3.
//     Same sequence in IDLE -> 0 pulses.
//  6. (MU0_BREAKPOINT_EN) bpArm=1, bpAddr=16'h0004, pc steps 0..4 -> BREAK at pc=4,
//     haltReason=2; toggle start -> RUN, reason 0.

Source files
------------

// File: rtl/mu0_run_ctrl_if.sv
// Handshake bundle between the uart/top level and the mu0 run sequencer.
// Optional feature macro: MU0_BREAKPOINT_EN adds pc, bpAddr and bpArm.
interface mu0_run_ctrl_if #(
    parameter int PC_W = 16
);
    logic [3:0]  clkMode;
    logic        start;
    logic        done;
    logic        cpuClk;
    logic        cpuEdge;
    logic        enable;
    logic [1:0]  haltReason;
    logic [15:0] cycleCount;
`ifdef MU0_BREAKPOINT_EN
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] bpAddr;
    logic            bpArm;

    modport master (
        output clkMode, start, done, pc, bpAddr, bpArm,
        input  cpuClk, cpuEdge, enable, haltReason, cycleCount
    );
    modport slave (
        input  clkMode, start, done, pc, bpAddr, bpArm,
        output cpuClk, cpuEdge, enable, haltReason, cycleCount
    );
`else
    modport master (
        output clkMode, start, done,
        input  cpuClk, cpuEdge, enable, haltReason, cycleCount
    );
    modport slave (
        input  clkMode, start, done,
        output cpuClk, cpuEdge, enable, haltReason, cycleCount
    );
`endif
endinterface

// File: rtl/mu0_run_ctrl.sv
// mu0 run/clock sequencer: start-toggle run requests, run-state FSM, gated CPU
// clock level with a rising-edge strobe, and a saturating CPU cycle counter.
// Optional feature macro: MU0_BREAKPOINT_EN (pc/bpAddr breakpoint -> BREAK state).
module mu0_run_ctrl #(
    parameter int SLOW_DIV = 6318000,
    parameter int CNT_W    = 32
) (
    input  logic          clk,
    input  logic          reset,
    mu0_run_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT, S_BREAK} state_t;

    state_t            state_q, state_d;
    logic              start_seen_q, start_seen_d;
    logic              primed_q, primed_d;
    logic [3:0]        mode_q, mode_d;
    logic [CNT_W-1:0]  div_q, div_d;
    logic              g_q, g_d;
    logic              cpu_clk_q, cpu_clk_d;
    logic              cpu_edge_q, cpu_edge_d;
    logic              enable_q, enable_d;
    logic [1:0]        reason_q, reason_d;
    logic [15:0]       count_q, count_d;

    logic              run_req;
    logic              mode_chg;
    logic              bp_hit;

    // Next-state logic: request detect, clock generator, FSM, strobe and counter
    always_comb begin
        // The first clk after reset only captures start, so a start level
        // held through reset is never mistaken for a toggle.
        run_req      = primed_q && (bus.start != start_seen_q);
        start_seen_d = bus.start;
        primed_d     = 1'b1;

        // Generator runs regardless of state; a mode change restarts the divider.
        mode_d   = bus.clkMode;
        mode_chg = (bus.clkMode != mode_q);
        div_d    = '0;
        g_d      = 1'b0;
        case (bus.clkMode)
            4'd1: g_d = ~g_q;
            4'd2: begin
                if (div_q == CNT_W'(SLOW_DIV)) begin
                    g_d = ~g_q;
                end else begin
                    g_d = g_q;
                    if (!mode_chg) div_d = div_q + 1'b1;
                end
            end
            4'd4: g_d = 1'b1;
            default: g_d = 1'b0;
        endcase

`ifdef MU0_BREAKPOINT_EN
        bp_hit = (state_q == S_RUN) && cpu_edge_q && bus.bpArm && (bus.pc == bus.bpAddr);
`else
        bp_hit = 1'b0;
`endif

        // Priority: run request > done > breakpoint.
        state_d  = state_q;
        reason_d = reason_q;
        if (run_req) begin
            state_d  = S_RUN;
            reason_d = 2'd0;
        end else if (state_q == S_RUN && bus.done) begin
            state_d  = S_HALT;
            reason_d = 2'd1;
        end else if (bp_hit) begin
            state_d  = S_BREAK;
            reason_d = 2'd2;
        end

        // Gating on the next state drops cpuClk in the same clk as enable.
        enable_d   = (state_d == S_RUN);
        cpu_clk_d  = g_d & enable_d;
        cpu_edge_d = cpu_clk_d & ~cpu_clk_q;

        if (run_req)
            count_d = '0;
        else if (cpu_edge_d && count_q != 16'hFFFF)
            count_d = count_q + 16'd1;
        else
            count_d = count_q;
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            start_seen_q <= 1'b0;
            primed_q     <= 1'b0;
            mode_q       <= 4'd0;
            div_q        <= '0;
            g_q          <= 1'b0;
            cpu_clk_q    <= 1'b0;
            cpu_edge_q   <= 1'b0;
            enable_q     <= 1'b0;
            reason_q     <= 2'd0;
            count_q      <= 16'd0;
        end else begin
            state_q      <= state_d;
            start_seen_q <= start_seen_d;
            primed_q     <= primed_d;
            mode_q       <= mode_d;
            div_q        <= div_d;
            g_q          <= g_d;
            cpu_clk_q    <= cpu_clk_d;
            cpu_edge_q   <= cpu_edge_d;
            enable_q     <= enable_d;
            reason_q     <= reason_d;
            count_q      <= count_d;
        end
    end

    assign bus.cpuClk     = cpu_clk_q;
    assign bus.cpuEdge    = cpu_edge_q;
    assign bus.enable     = enable_q;
    assign bus.haltReason = reason_q;
    assign bus.cycleCount = count_q;
endmodule

// File: tb/tb_mu0_run_ctrl.sv
// Self-checking bench for mu0_run_ctrl: directed scenarios plus random stimulus,
// every clk compared against a behavioural model of the run/clock rules.
module tb_mu0_run_ctrl;
    localparam int D = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mu0_run_ctrl_if #(.PC_W(16)) bus ();
    mu0_run_ctrl #(.SLOW_DIV(D), .CNT_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_chk = 0;
    int n_err = 0;

    // Model state
    bit m_seen, m_primed, m_run, m_g, m_clk, m_edge;
    int m_reason, m_count, m_prev, m_n;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_seen = 0; m_primed = 0; m_run = 0; m_g = 0; m_clk = 0; m_edge = 0;
        m_reason = 0; m_count = 0; m_prev = 0; m_n = 0;
    endtask

    // One clk of the rules, using the inputs present before the edge.
    task automatic model_step();
        bit req, ng, bp, nclk;
        int mode;
        req = m_primed && (bus.start != m_seen);
        m_seen = bus.start;
        m_primed = 1;
        mode = int'(bus.clkMode);
        // SLOW: the clk on which the mode is entered counts as tick 0;
        // the level flips every D+1 ticks after that.
        if (mode != m_prev) m_n = 0; else m_n++;
        case (mode)
            1: ng = !m_g;
            2: ng = (m_n > 0 && (m_n % (D + 1)) == 0) ? !m_g : m_g;
            4: ng = 1;
            default: ng = 0;
        endcase
        m_prev = mode;
        bp = 0;
`ifdef MU0_BREAKPOINT_EN
        bp = m_run && m_edge && bus.bpArm && (bus.pc == bus.bpAddr);
`endif
        if (req) begin
            m_run = 1; m_reason = 0; m_count = 0;
        end else if (m_run && bus.done) begin
            m_run = 0; m_reason = 1;
        end else if (bp) begin
            m_run = 0; m_reason = 2;
        end
        m_g = ng;
        nclk = ng && m_run;
        m_edge = nclk && !m_clk;
        m_clk = nclk;
        if (!req && m_edge && m_count < 65535) m_count++;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".enable"}, 32'(bus.enable), 32'(m_run));
        chk({tag, ".cpuClk"}, 32'(bus.cpuClk), 32'(m_clk));
        chk({tag, ".cpuEdge"}, 32'(bus.cpuEdge), 32'(m_edge));
        chk({tag, ".haltReason"}, 32'(bus.haltReason), 32'(m_reason));
        chk({tag, ".cycleCount"}, 32'(bus.cycleCount), 32'(m_count));
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".enable"}, 32'(bus.enable), 0);
        chk({tag, ".cpuClk"}, 32'(bus.cpuClk), 0);
        chk({tag, ".cpuEdge"}, 32'(bus.cpuEdge), 0);
        chk({tag, ".haltReason"}, 32'(bus.haltReason), 0);
        chk({tag, ".cycleCount"}, 32'(bus.cycleCount), 0);
    endtask

    int edges;

    initial begin
        bus.clkMode = 4'd0;
        bus.start   = 1'b1;
        bus.done    = 1'b0;
`ifdef MU0_BREAKPOINT_EN
        bus.pc = 16'h0; bus.bpAddr = 16'h0004; bus.bpArm = 1'b0;
`endif
        model_reset();
        #12;
        check_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // 1: start held high through reset is not a request
        for (int i = 0; i < 4; i++) begin
            tick("no_spurious");
            chk("no_spurious.enable0", 32'(bus.enable), 0);
        end

        // 2: FAST run, edge every other clk, 5 counted edges in 10 clks
        bus.clkMode = 4'd1;
        tick("fast_setup");
        bus.start = ~bus.start;
        tick("fast_req");
        chk("fast_req.enable1", 32'(bus.enable), 1);
        edges = 0;
        for (int i = 0; i < 10; i++) begin
            tick("fast_run");
            edges += int'(bus.cpuEdge);
        end
        chk("fast.edges", 32'(edges), 5);
        chk("fast.count", 32'(bus.cycleCount), 5);

        // 3: SLOW, then switch to FAST mid-count
        bus.clkMode = 4'd2;
        for (int i = 0; i < 21; i++) tick("slow");
        bus.clkMode = 4'd1;
        for (int i = 0; i < 6; i++) tick("slow2fast");
        bus.clkMode = 4'd2;
        for (int i = 0; i < 10; i++) tick("fast2slow");

        // 4: done halts; done with a request stays running with a cleared count
        bus.clkMode = 4'd1;
        bus.done = 1'b1;
        tick("done");
        bus.done = 1'b0;
        chk("done.enable0", 32'(bus.enable), 0);
        chk("done.cpuClk0", 32'(bus.cpuClk), 0);
        chk("done.reason1", 32'(bus.haltReason), 1);
        for (int i = 0; i < 4; i++) tick("halted");
        bus.start = ~bus.start;
        tick("resume");
        for (int i = 0; i < 5; i++) tick("resumed");
        bus.done = 1'b1;
        bus.start = ~bus.start;
        tick("done_and_req");
        bus.done = 1'b0;
        chk("done_and_req.enable1", 32'(bus.enable), 1);
        chk("done_and_req.count0", 32'(bus.cycleCount), 0);

        // 5: manual clocking, in RUN then in HALT
        bus.clkMode = 4'd3;
        tick("man_setup");
        tick("man_setup");
        bus.start = ~bus.start;
        tick("man_req");
        for (int k = 0; k < 3; k++) begin
            bus.clkMode = 4'd4; tick("man_on");  tick("man_on");
            bus.clkMode = 4'd3; tick("man_off"); tick("man_off");
        end
        chk("manual_run.count3", 32'(bus.cycleCount), 3);
        bus.done = 1'b1;
        tick("man_done");
        bus.done = 1'b0;
        edges = 0;
        for (int k = 0; k < 3; k++) begin
            bus.clkMode = 4'd4; tick("man_on_h");  edges += int'(bus.cpuEdge);
            tick("man_on_h");  edges += int'(bus.cpuEdge);
            bus.clkMode = 4'd3; tick("man_off_h"); edges += int'(bus.cpuEdge);
            tick("man_off_h"); edges += int'(bus.cpuEdge);
        end
        chk("manual_halt.edges0", 32'(edges), 0);
        chk("manual_halt.count3", 32'(bus.cycleCount), 3);

`ifdef MU0_BREAKPOINT_EN
        // 6: breakpoint at pc 4, pc advancing on each CPU edge
        bus.clkMode = 4'd1;
        bus.bpArm = 1'b1;
        bus.pc = 16'h0;
        bus.start = ~bus.start;
        tick("bp_req");
        for (int i = 0; i < 30 && bus.enable; i++) begin
            if (bus.cpuEdge && bus.pc < 16'h4) bus.pc = bus.pc + 16'h1;
            tick("bp_run");
        end
        chk("bp.reason2", 32'(bus.haltReason), 2);
        chk("bp.enable0", 32'(bus.enable), 0);
        chk("bp.pc4", 32'(bus.pc), 4);
        bus.bpArm = 1'b0;
        bus.start = ~bus.start;
        tick("bp_resume");
        chk("bp_resume.reason0", 32'(bus.haltReason), 0);
        chk("bp_resume.enable1", 32'(bus.enable), 1);
`endif

        // Reset in the middle of a run
        bus.clkMode = 4'd1;
        bus.start = ~bus.start;
        for (int i = 0; i < 5; i++) tick("pre_reset");
        #3;
        reset = 1'b1;
        #1;
        check_zero("mid_reset");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        tick("post_reset");

        // Random stimulus
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 11) == 0) bus.clkMode = 4'($urandom_range(0, 7));
            if ($urandom_range(0, 19) == 0) bus.start = ~bus.start;
            bus.done = ($urandom_range(0, 24) == 0);
`ifdef MU0_BREAKPOINT_EN
            bus.bpAddr = 16'h0003;
            bus.bpArm  = 1'($urandom_range(0, 1));
            bus.pc     = 16'($urandom_range(0, 7));
`endif
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
